wav_play_sched: RTL and testbench
=================================

# wav_play_sched

Playback scheduler between the SD sector reader and the WM8731 sample path. Issues SD sector read requests into a two-half (ping-pong) sample RAM, tracks which half is full, generates the RAM read address for the DAC side, and handles start/stop, looping and underrun muting. All logic runs on the 50 MHz system clock; the SD reader's `sec_done` and the DAC-side `wav_rden` are already synchronised to that clock.

## Interface
- `SEC_WORDS`, 256: 16-bit samples per 512-byte sector (power of two).
- `AW`, 9: RAM word-address width, equal to log2(2*SEC_WORDS).
- `UCW`, 16: underrun counter width.

Ports:
- `clk_50m` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins playback when idle.
- `stop` in 1: one-cycle pulse; aborts playback.
- `loop_en` in 1: when high, wrap to `start_sec` after the last sector.
- `start_sec` in 32: first data sector; sampled on an accepted `start`.
- `num_secs` in 32: sectors to play; sampled on an accepted `start`.
- `sd_ready` in 1: SD card initialised.
- `read_req` out 1: one-cycle pulse requesting one sector read.
- `read_sec` out 32: sector address; stable from `read_req` until `sec_done`.
- `wr_half` out 1: RAM half receiving the current sector (RAM write address MSB).
- `sec_done` in 1: one-cycle pulse; the requested sector is fully written to RAM.
- `wav_rden` in 1: one-cycle pulse per sample consumed by the DAC side.
- `rd_addr` out AW: RAM read address.
- `mute` out 1: high means the DAC side must output zero.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when playback ends, whether by completion or abort.
- `underrun_cnt` out UCW: saturating count of underrun reads.

## Operation
- State register: IDLE, WAIT_INIT, FILL, PLAY, DRAIN, ABORT.
- Internal registers:
  - `full[1:0]`: per-half full flags.
  - `outstanding`: a read has been issued and its `sec_done` has not yet arrived.
  - `sec_ptr` (32 bits) and `secs_left` (32 bits).
  - `rd_ptr` (AW bits); `rd_addr = rd_ptr`, and `rd_half = rd_ptr[AW-1]`.
- IDLE: `start` with `num_secs != 0` loads `sec_ptr`, `secs_left`, clears `full`, `rd_ptr` and `underrun_cnt`, then goes to WAIT_INIT. `start` with `num_secs == 0` is ignored.
- WAIT_INIT: go to FILL when `sd_ready` is high.
- Issue rule, applied in FILL, PLAY and DRAIN:
  - Condition: `!outstanding`, `secs_left != 0`, and `full[wr_half] == 0`.
  - Action: pulse `read_req` with `read_sec = sec_ptr`, set `outstanding`.
  - At most one read is outstanding at any time.
- On `sec_done` with `outstanding` set:
  - Set `full[wr_half]`, toggle `wr_half`, clear `outstanding`.
  - Increment `sec_ptr` and decrement `secs_left`.
  - If `secs_left` becomes 0 and `loop_en` is high, reload both from the latched `start_sec`/`num_secs`.
- `sec_done` without `outstanding` is ignored.
- FILL: go to PLAY once both halves are full, or once `secs_left == 0` with no read outstanding (short file). `mute` stays high in FILL.
- PLAY, on `wav_rden`:
  - If `full[rd_half]`: increment `rd_ptr`. When the low AW-1 bits are all ones, also clear `full[rd_half]`, because the increment carries into the half bit.
  - Else (underrun): `rd_ptr` holds, `mute` is high for that read, and `underrun_cnt` increments, saturating at all-ones.
- PLAY → DRAIN when `secs_left == 0` and no read is outstanding.
- DRAIN: go to IDLE, pulsing `done`, when `full == 2'b00`.
- `stop` in WAIT_INIT, FILL, PLAY or DRAIN:
  - If a read is outstanding, go to ABORT (the SD read cannot be cancelled). ABORT waits for `sec_done`, then goes to IDLE with a `done` pulse.
  - Otherwise go straight to IDLE with a `done` pulse.
  - `mute` goes high immediately.
- `start` while `busy` is ignored; `stop` in IDLE is ignored.

## Timing
- Reset values: state IDLE, `read_req` 0, `read_sec` 0, `wr_half` 0, `rd_addr` 0, `mute` 1, `busy` 0, `done` 0, `underrun_cnt` 0, `full` 00, `outstanding` 0.
- All outputs are registered.
- `read_req` rises at the earliest one cycle after the issue condition becomes true.
- `full` is updated in the cycle after `sec_done`/`wav_rden`. A new read to a freed half may be issued no earlier than the cycle after that half is cleared.
- `mute` is combinational-free:
  - It is registered high in IDLE, WAIT_INIT, FILL and ABORT.
  - In PLAY and DRAIN it is registered as `!full[rd_half]`, so it is valid for the sample read following the update.
- Simultaneous `sec_done` on one half and a last-sample `wav_rden` on the other half: both flag updates occur in the same cycle.
- Simultaneous `stop` and `sec_done`: the sector is accepted (`outstanding` cleared) and the block goes directly to IDLE.
- `secs_left` is 32-bit unsigned with no wrap below 0; the `loop_en` reload happens in the same cycle as the decrement.

## Structure
- Shared package `wav_pkg`:
  - state enum `sched_state_t`;
  - constants `SEC_WORDS`, `AW`;
  - sector-address type `sec_addr_t` (32 bits).
- One natural sub-module, `pingpong_tracker`: `full[1:0]`, `wr_half`, `rd_ptr`, underrun detection and counting. The parent holds the FSM, `sec_ptr`/`secs_left` and request issue.

## Test plan
- `start_sec=0x2000`, `num_secs=4`, `sd_ready=1`, bench answers each `read_req` with `sec_done` after 100 cycles:
  - `read_sec` sequence is 0x2000..0x2003 and `wr_half` sequence is 0,1,0,1;
  - `mute` drops only after two `sec_done`s;
  - after 1024 `wav_rden`: `done` pulses, `busy` falls, `underrun_cnt = 0`.
- Starve the bench (no `sec_done` for sector 3) while `wav_rden` continues: `rd_addr` freezes at 256, `mute` is high, `underrun_cnt` counts each read; supplying `sec_done` resumes playback.
- `loop_en=1`, `num_secs=2`, `start_sec=0x10`: `read_sec` sequence is 0x10, 0x11, 0x10, 0x11…; never enters DRAIN.
- `stop` issued 10 cycles after a `read_req`, `sec_done` 50 cycles later: state is ABORT and `mute` is 1 until then; `done` pulses once after `sec_done`; no further `read_req`.
- `num_secs=0` start is ignored (`busy` stays 0); `start` with `sd_ready=0` holds in WAIT_INIT with no `read_req` until `sd_ready` rises.
- Assert `rst` mid-PLAY: all outputs take their reset values asynchronously; a subsequent `start` replays from `start_sec`.

Source files
------------

// File: rtl/wav_pkg.sv
// wav_pkg: shared types and constants for the wav playback scheduler.
//   SEC_WORDS  16-bit samples per 512-byte SD sector
//   AW         sample RAM word-address width (two sector-sized halves)
//   UCW        underrun counter width
package wav_pkg;
  localparam int SEC_WORDS = 256;
  localparam int AW = $clog2(2 * SEC_WORDS);
  localparam int UCW = 16;
  typedef logic [31:0] sec_addr_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_FILL,
    S_PLAY,
    S_DRAIN,
    S_ABORT
  } sched_state_t;
endpackage

// File: rtl/wav_play_sched_pingpong_tracker.sv
// pingpong_tracker: full flags, write half, read pointer and underrun count of the ping-pong sample RAM.
//   clr_i           restart: empty both halves, rewind both pointers, zero the underrun count
//   fill_i          accepted sector completion into the current write half
//   rd_en_i         sample consumed by the DAC side (only while playing)
//   full_o          per-half full flags
//   wr_half_o       half receiving the next sector
//   rd_ptr_o        RAM read address
//   underrun_cnt_o  saturating count of reads from an empty half
//   rd_mute_o       next-cycle "read half empty", for the registered mute
module pingpong_tracker #(
  parameter int SEC_WORDS = wav_pkg::SEC_WORDS,
  parameter int AW = wav_pkg::AW,
  parameter int UCW = wav_pkg::UCW
) (
  input  logic           clk_50m,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           fill_i,
  input  logic           rd_en_i,
  output logic [1:0]     full_o,
  output logic           wr_half_o,
  output logic [AW-1:0]  rd_ptr_o,
  output logic [UCW-1:0] underrun_cnt_o,
  output logic           rd_mute_o
);
  logic [1:0] full_q, full_d;
  logic wr_half_q, wr_half_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [UCW-1:0] ucnt_q, ucnt_d;
  logic rd_half, hit, miss, wrap;
  assign rd_half = rd_ptr_q[AW-1];
  assign hit = rd_en_i && full_q[rd_half];
  assign miss = rd_en_i && !full_q[rd_half];
  // last word of a half: the increment carries into the half bit, so that half is now free
  assign wrap = hit && (rd_ptr_q[AW-2:0] == (AW-1)'(SEC_WORDS - 1));
  // fill and wrap never touch the same half: a half is only filled while empty and only read while full
  always_comb begin
    full_d = full_q;
    if (fill_i) full_d[wr_half_q] = 1'b1;
    if (wrap) full_d[rd_half] = 1'b0;
    if (clr_i) full_d = 2'b00;
  end
  assign wr_half_d = clr_i ? 1'b0 : wr_half_q ^ fill_i;
  assign rd_ptr_d = clr_i ? '0 : rd_ptr_q + AW'(hit);
  assign ucnt_d = clr_i ? '0 : (miss && !(&ucnt_q)) ? ucnt_q + UCW'(1) : ucnt_q;
  assign rd_mute_o = !full_d[rd_ptr_d[AW-1]];
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      full_q <= 2'b00;
      wr_half_q <= 1'b0;
      rd_ptr_q <= '0;
      ucnt_q <= '0;
    end else begin
      full_q <= full_d;
      wr_half_q <= wr_half_d;
      rd_ptr_q <= rd_ptr_d;
      ucnt_q <= ucnt_d;
    end
  end
  assign full_o = full_q;
  assign wr_half_o = wr_half_q;
  assign rd_ptr_o = rd_ptr_q;
  assign underrun_cnt_o = ucnt_q;
endmodule

// File: rtl/wav_play_sched.sv
// wav_play_sched: schedules SD sector reads into a ping-pong sample RAM and paces the DAC-side read address.
//   start/stop          one-cycle playback control pulses
//   loop_en             restart from start_sec after the last sector
//   start_sec/num_secs  file extent, latched on an accepted start
//   sd_ready            SD card initialised
//   read_req/read_sec   one-cycle sector read request and its address
//   wr_half             RAM half receiving the current sector
//   sec_done            requested sector fully written
//   wav_rden            one sample consumed by the DAC side
//   rd_addr             RAM read address
//   mute/busy/done      DAC zeroing, activity, end-of-playback pulse
//   underrun_cnt        saturating count of reads from an empty half
module wav_play_sched #(
  parameter int SEC_WORDS = wav_pkg::SEC_WORDS,
  parameter int AW = wav_pkg::AW,
  parameter int UCW = wav_pkg::UCW
) (
  input  logic           clk_50m,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic           loop_en,
  input  logic [31:0]    start_sec,
  input  logic [31:0]    num_secs,
  input  logic           sd_ready,
  output logic           read_req,
  output logic [31:0]    read_sec,
  output logic           wr_half,
  input  logic           sec_done,
  input  logic           wav_rden,
  output logic [AW-1:0]  rd_addr,
  output logic           mute,
  output logic           busy,
  output logic           done,
  output logic [UCW-1:0] underrun_cnt
);
  import wav_pkg::*;
  sched_state_t state_q, state_d;
  sec_addr_t sec_ptr_q, sec_ptr_d, secs_left_q, secs_left_d, start_sec_q, num_secs_q, read_sec_q;
  logic outstanding_q, outstanding_d, read_req_q, mute_q, mute_d, busy_q, done_q;
  logic accept, active, stopping, issue, load, reading, trk_mute;
  logic [1:0] full;
  assign accept = sec_done && outstanding_q;
  assign active = state_q inside {S_FILL, S_PLAY, S_DRAIN};
  assign stopping = stop && state_q inside {S_WAIT_INIT, S_FILL, S_PLAY, S_DRAIN};
  assign issue = active && !stop && !outstanding_q && secs_left_q != '0 && !full[wr_half];
  assign load = state_q == S_IDLE && start && num_secs != '0;
  assign reading = wav_rden && state_q inside {S_PLAY, S_DRAIN};
  pingpong_tracker #(.SEC_WORDS(SEC_WORDS), .AW(AW), .UCW(UCW)) u_trk (
    .clk_50m(clk_50m),
    .rst(rst),
    .clr_i(load),
    .fill_i(accept),
    .rd_en_i(reading),
    .full_o(full),
    .wr_half_o(wr_half),
    .rd_ptr_o(rd_addr),
    .underrun_cnt_o(underrun_cnt),
    .rd_mute_o(trk_mute)
  );
  // a stop coinciding with sec_done has nothing left in flight, so it skips ABORT
  always_comb begin
    state_d = state_q;
    if (stopping) state_d = (outstanding_q && !sec_done) ? S_ABORT : S_IDLE;
    else case (state_q)
      S_IDLE:      state_d = load ? S_WAIT_INIT : S_IDLE;
      S_WAIT_INIT: state_d = sd_ready ? S_FILL : S_WAIT_INIT;
      S_FILL:      state_d = (full == 2'b11 || (secs_left_q == '0 && !outstanding_q)) ? S_PLAY : S_FILL;
      S_PLAY:      state_d = (secs_left_q == '0 && !outstanding_q) ? S_DRAIN : S_PLAY;
      S_DRAIN:     state_d = (full == 2'b00) ? S_IDLE : S_DRAIN;
      S_ABORT:     state_d = sec_done ? S_IDLE : S_ABORT;
      default:     state_d = S_IDLE;
    endcase
  end
  // looping reloads in the same cycle the count would reach zero, so secs_left never reads 0 while looping
  always_comb begin
    sec_ptr_d = sec_ptr_q;
    secs_left_d = secs_left_q;
    if (load) begin
      sec_ptr_d = start_sec;
      secs_left_d = num_secs;
    end else if (accept) begin
      sec_ptr_d = sec_ptr_q + 32'd1;
      secs_left_d = secs_left_q - 32'd1;
      if (secs_left_d == '0 && loop_en) begin
        sec_ptr_d = start_sec_q;
        secs_left_d = num_secs_q;
      end
    end
  end
  assign outstanding_d = issue ? 1'b1 : accept ? 1'b0 : outstanding_q;
  assign mute_d = (state_d inside {S_PLAY, S_DRAIN}) ? trk_mute : 1'b1;
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sec_ptr_q <= '0;
      secs_left_q <= '0;
      start_sec_q <= '0;
      num_secs_q <= '0;
      outstanding_q <= 1'b0;
      read_req_q <= 1'b0;
      read_sec_q <= '0;
      mute_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_ptr_q <= sec_ptr_d;
      secs_left_q <= secs_left_d;
      start_sec_q <= load ? start_sec : start_sec_q;
      num_secs_q <= load ? num_secs : num_secs_q;
      outstanding_q <= outstanding_d;
      read_req_q <= issue;
      read_sec_q <= issue ? sec_ptr_q : read_sec_q;
      mute_q <= mute_d;
      busy_q <= state_d != S_IDLE;
      done_q <= state_q != S_IDLE && state_d == S_IDLE;
    end
  end
  assign read_req = read_req_q;
  assign read_sec = read_sec_q;
  assign mute = mute_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_wav_play_sched.sv
// tb_wav_play_sched: directed scenarios for wav_play_sched with an SD reader model answering read_req.
module tb_wav_play_sched;
  import wav_pkg::*;
  logic clk_50m = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic sd_ready = 1'b0, sec_done = 1'b0, wav_rden = 1'b0;
  logic [31:0] start_sec = '0, num_secs = '0, read_sec;
  logic read_req, wr_half, mute, busy, done;
  logic [8:0] rd_addr;
  logic [15:0] underrun_cnt;
  int checks = 0, errors = 0;
  int resp_delay = 100, hold_after = 1000, n_secdone = 0, cnt = 0;
  logic [31:0] req_log[$];
  logic half_log[$];

  always #5 clk_50m = ~clk_50m;

  wav_play_sched dut (
    .clk_50m(clk_50m), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .start_sec(start_sec), .num_secs(num_secs), .sd_ready(sd_ready),
    .read_req(read_req), .read_sec(read_sec), .wr_half(wr_half), .sec_done(sec_done),
    .wav_rden(wav_rden), .rd_addr(rd_addr), .mute(mute), .busy(busy), .done(done),
    .underrun_cnt(underrun_cnt)
  );

  // SD reader model: logs each request, answers resp_delay cycles later, withholds answers past hold_after
  initial forever begin
    @(posedge clk_50m);
    #2;
    sec_done = 1'b0;
    if (rst) cnt = 0;
    else if (read_req) begin
      req_log.push_back(read_sec);
      half_log.push_back(wr_half);
      cnt = resp_delay;
    end else if (cnt > 1) cnt--;
    else if (cnt == 1 && n_secdone < hold_after) begin
      cnt = 0;
      sec_done = 1'b1;
      n_secdone++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic rd(input int n, output int dn);
    dn = 0;
    for (int i = 0; i < n; i++) begin
      wav_rden = 1'b1;
      cyc(1);
      wav_rden = 1'b0;
      if (done) dn++;
      for (int k = 0; k < 3; k++) begin
        cyc(1);
        if (done) dn++;
      end
    end
  endtask

  task automatic wait_unmute(input int lim);
    for (int i = 0; i < lim && mute !== 1'b0; i++) cyc(1);
  endtask

  task automatic setup(input logic [31:0] ss, input logic [31:0] ns, input int dly, input int hold);
    start_sec = ss;
    num_secs = ns;
    resp_delay = dly;
    hold_after = hold;
    n_secdone = 0;
    req_log.delete();
    half_log.delete();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (read_req !== 1'b0) begin errors++; $display("FAIL rst_read_req got %0b exp 0", read_req); end
    checks++; if (read_sec !== 32'h0) begin errors++; $display("FAIL rst_read_sec got %0h exp 0", read_sec); end
    checks++; if (wr_half !== 1'b0) begin errors++; $display("FAIL rst_wr_half got %0b exp 0", wr_half); end
    checks++; if (rd_addr !== 9'd0) begin errors++; $display("FAIL rst_rd_addr got %0d exp 0", rd_addr); end
    checks++; if (mute !== 1'b1) begin errors++; $display("FAIL rst_mute got %0b exp 1", mute); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL rst_underrun got %0d exp 0", underrun_cnt); end
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_basic();
    int dn, md;
    loop_en = 1'b0;
    sd_ready = 1'b1;
    setup(32'h2000, 32'd4, 100, 1000);
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b exp 1", busy); end
    wait_unmute(2000);
    md = n_secdone;
    checks++; if (mute !== 1'b0) begin errors++; $display("FAIL basic_unmute got %0b exp 0", mute); end
    checks++; if (md != 2) begin errors++; $display("FAIL basic_unmute_secdone got %0d exp 2", md); end
    rd(1024, dn);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (done) dn++;
    end
    checks++; if (dn != 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", dn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %0b exp 0", busy); end
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL basic_underrun got %0d exp 0", underrun_cnt); end
    checks++; if (rd_addr !== 9'd0) begin errors++; $display("FAIL basic_rd_addr got %0d exp 0", rd_addr); end
    checks++; if (req_log.size() != 4) begin errors++; $display("FAIL basic_req_count got %0d exp 4", req_log.size()); end
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      checks++; if (req_log[i] !== 32'h2000 + i) begin errors++; $display("FAIL basic_read_sec[%0d] got %0h exp %0h", i, req_log[i], 32'h2000 + i); end
      checks++; if (half_log[i] !== 1'(i & 1)) begin errors++; $display("FAIL basic_wr_half[%0d] got %0b exp %0b", i, half_log[i], i & 1); end
    end
  endtask

  task automatic test_underrun();
    int dn;
    setup(32'h2000, 32'd4, 100, 3);
    pulse_start();
    wait_unmute(2000);
    rd(768, dn);
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL starve_pre_underrun got %0d exp 0", underrun_cnt); end
    checks++; if (rd_addr !== 9'd256) begin errors++; $display("FAIL starve_rd_addr got %0d exp 256", rd_addr); end
    checks++; if (mute !== 1'b1) begin errors++; $display("FAIL starve_mute got %0b exp 1", mute); end
    rd(5, dn);
    checks++; if (underrun_cnt !== 16'd5) begin errors++; $display("FAIL starve_underrun got %0d exp 5", underrun_cnt); end
    checks++; if (rd_addr !== 9'd256) begin errors++; $display("FAIL starve_rd_addr_frozen got %0d exp 256", rd_addr); end
    checks++; if (mute !== 1'b1) begin errors++; $display("FAIL starve_mute_hold got %0b exp 1", mute); end
    hold_after = 1000;
    wait_unmute(50);
    checks++; if (mute !== 1'b0) begin errors++; $display("FAIL starve_resume_mute got %0b exp 0", mute); end
    rd(256, dn);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (done) dn++;
    end
    checks++; if (dn != 1) begin errors++; $display("FAIL starve_done_pulses got %0d exp 1", dn); end
    checks++; if (underrun_cnt !== 16'd5) begin errors++; $display("FAIL starve_final_underrun got %0d exp 5", underrun_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_busy_end got %0b exp 0", busy); end
  endtask

  task automatic test_loop();
    bit drain_seen;
    drain_seen = 1'b0;
    loop_en = 1'b1;
    setup(32'h10, 32'd2, 20, 1000);
    pulse_start();
    wait_unmute(500);
    for (int c = 0; c < 8000 && req_log.size() < 6; c++) begin
      wav_rden = (c % 4 == 0);
      cyc(1);
      if (dut.state_q == S_DRAIN) drain_seen = 1'b1;
    end
    wav_rden = 1'b0;
    checks++; if (req_log.size() < 6) begin errors++; $display("FAIL loop_req_count got %0d exp 6", req_log.size()); end
    for (int i = 0; i < 6 && i < req_log.size(); i++) begin
      checks++; if (req_log[i] !== ((i & 1) != 0 ? 32'h11 : 32'h10)) begin errors++; $display("FAIL loop_read_sec[%0d] got %0h exp %0h", i, req_log[i], (i & 1) != 0 ? 32'h11 : 32'h10); end
    end
    checks++; if (drain_seen) begin errors++; $display("FAIL loop_drain got 1 exp 0"); end
    checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL loop_underrun got %0d exp 0", underrun_cnt); end
    pulse_stop();
    for (int i = 0; i < 100 && busy !== 1'b0; i++) cyc(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop_busy got %0b exp 0", busy); end
    loop_en = 1'b0;
  endtask

  task automatic test_stop();
    int dn;
    setup(32'h300, 32'd4, 60, 1000);
    pulse_start();
    for (int i = 0; i < 20 && req_log.size() == 0; i++) cyc(1);
    checks++; if (req_log.size() != 1) begin errors++; $display("FAIL stop_first_req got %0d exp 1", req_log.size()); end
    cyc(9);
    pulse_stop();
    checks++; if (dut.state_q !== S_ABORT) begin errors++; $display("FAIL stop_state got %0d exp %0d", dut.state_q, S_ABORT); end
    checks++; if (mute !== 1'b1) begin errors++; $display("FAIL stop_mute got %0b exp 1", mute); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy got %0b exp 1", busy); end
    dn = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (done) dn++;
    end
    checks++; if (dn != 1) begin errors++; $display("FAIL stop_done_pulses got %0d exp 1", dn); end
    checks++; if (n_secdone != 1) begin errors++; $display("FAIL stop_secdone got %0d exp 1", n_secdone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy_end got %0b exp 0", busy); end
    checks++; if (req_log.size() != 1) begin errors++; $display("FAIL stop_no_more_req got %0d exp 1", req_log.size()); end
  endtask

  task automatic test_ignore();
    setup(32'h40, 32'd0, 20, 1000);
    sd_ready = 1'b1;
    pulse_start();
    cyc(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_secs_busy got %0b exp 0", busy); end
    num_secs = 32'd2;
    sd_ready = 1'b0;
    pulse_start();
    cyc(20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_init_busy got %0b exp 1", busy); end
    checks++; if (dut.state_q !== S_WAIT_INIT) begin errors++; $display("FAIL wait_init_state got %0d exp %0d", dut.state_q, S_WAIT_INIT); end
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL wait_init_no_req got %0d exp 0", req_log.size()); end
    sd_ready = 1'b1;
    for (int i = 0; i < 10 && req_log.size() == 0; i++) cyc(1);
    checks++; if (req_log.size() != 1) begin errors++; $display("FAIL ready_req got %0d exp 1", req_log.size()); end
    if (req_log.size() > 0) begin
      checks++; if (req_log[0] !== 32'h40) begin errors++; $display("FAIL ready_read_sec got %0h exp 40", req_log[0]); end
    end
    pulse_stop();
    for (int i = 0; i < 100 && busy !== 1'b0; i++) cyc(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ready_stop_busy got %0b exp 0", busy); end
  endtask

  task automatic test_midreset();
    int dn;
    setup(32'h2000, 32'd4, 100, 1000);
    pulse_start();
    wait_unmute(2000);
    rd(10, dn);
    #2 rst = 1'b1;
    #1;
    checks++; if (read_sec !== 32'h0) begin errors++; $display("FAIL mid_rst_read_sec got %0h exp 0", read_sec); end
    checks++; if (rd_addr !== 9'd0) begin errors++; $display("FAIL mid_rst_rd_addr got %0d exp 0", rd_addr); end
    checks++; if (mute !== 1'b1) begin errors++; $display("FAIL mid_rst_mute got %0b exp 1", mute); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %0b exp 0", busy); end
    checks++; if (wr_half !== 1'b0 || read_req !== 1'b0 || done !== 1'b0 || underrun_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_misc got %0b%0b%0b/%0d exp 000/0", wr_half, read_req, done, underrun_cnt); end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    setup(32'h2000, 32'd4, 100, 1000);
    pulse_start();
    for (int i = 0; i < 20 && req_log.size() == 0; i++) cyc(1);
    checks++; if (req_log.size() != 1) begin errors++; $display("FAIL replay_req got %0d exp 1", req_log.size()); end
    if (req_log.size() > 0) begin
      checks++; if (req_log[0] !== 32'h2000) begin errors++; $display("FAIL replay_read_sec got %0h exp 2000", req_log[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_loop();
    test_stop();
    test_ignore();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
